sar_search: RTL

Successive-approximation search controller that recovers an unknown WIDTH-bit value A by querying an external magnitude comparator. The block drives the comparator's B operand with trial codes and reads back its A_lt_B / A_gt_B / A_eq_B flags. It resolves A in at most WIDTH compare cycles. It sits beside the 8-bit comparator as its questioner: the comparator answers one comparison, and this block decides the next one.

---
 rtl/sar_search.sv | 99 +++++++++
 1 files changed

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives trial codes on B to an
// external magnitude comparator and resolves the unknown operand A bit by bit.
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] B,
  input  logic             A_lt_B,
  input  logic             A_gt_B,
  input  logic             A_eq_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE, TEST} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0] bit_cur;
  logic [WIDTH-1:0] bit_nxt;
  logic [WIDTH-1:0] acc_n;
  logic             flags_ok;

  // Decision for the bit under test; the next trial bit sits one position lower.
  always_comb begin
    bit_cur  = WIDTH'(1) << idx;
    bit_nxt  = bit_cur >> 1;
    acc_n    = A_gt_B ? (acc | bit_cur) : acc;
    flags_ok = $onehot({A_lt_B, A_gt_B, A_eq_B});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      idx    <= '0;
      B      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            idx    <= IDX_W'(WIDTH - 1);
            B      <= {1'b1, {(WIDTH-1){1'b0}}};
            busy   <= 1'b1;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            state  <= TEST;
          end
        end
        TEST: begin
          if (!flags_ok) begin
            err    <= 1'b1;
            found  <= 1'b0;
            result <= '0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (A_eq_B) begin
            result <= B;
            found  <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (idx == '0) begin
            // Last bit decided without an exact hit (only possible for A == 0).
            result <= acc_n;
            found  <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            acc <= acc_n;
            idx <= idx - 1'b1;
            B   <= acc_n | bit_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
